// File: rtl/conv_mem_pkg.sv
// Shared widths, depth helper and FSM encoding for the conv controller memory responder.
// Latency: n/a. Backpressure: n/a.
package conv_mem_pkg;

  localparam int DefDataWidth    = 32;
  localparam int DefMaxAddrWidth = 32;
  localparam int DefDepthLog2    = 12;
  localparam int DefCountWidth   = 18;

  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

  localparam int MemDepth = depth_of(DefDepthLog2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/conv_mem_array.sv
// Dual-port word RAM: one registered read port, one write port. Read latency 1, no backpressure.
// CONV_MEM_RDFWD_EN selects write-first forwarding on same-address collisions (default read-first).
module conv_mem_array
  import conv_mem_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int DepthLog2 = DefDepthLog2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [DepthLog2-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [DepthLog2-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data
);

  localparam int Depth = depth_of(DepthLog2);

  logic [DataWidth-1:0] mem [Depth];

  // Storage is never reset; only the output register is.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data <= '0;
`ifdef CONV_MEM_RDFWD_EN
      end else if (wr_en && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
`endif
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/conv_mem_responder.sv
// Memory responder for the conv controller: read stream, result capture, tag handshake, host preload.
// Read latency 1 cycle, no backpressure; illegal accesses are dropped and flagged (CONV_MEM_RDFWD_EN: forwarding).
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int DataWidth    = DefDataWidth,
  parameter int MaxAddrWidth = DefMaxAddrWidth,
  parameter int DepthLog2    = DefDepthLog2,
  parameter int CountWidth   = DefCountWidth
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [MaxAddrWidth-1:0] read_addr_in,
  input  logic                    read_en_in,
  output logic [DataWidth-1:0]    read_rdata_out,
  input  logic                    write_en_in,
  input  logic [DataWidth-1:0]    write_data_in,
  input  logic                    inst_finish_in,
  output logic                    inst_tag_out,
  input  logic                    start_in,
  input  logic [MaxAddrWidth-1:0] wr_base_in,
  input  logic                    host_wr_en_in,
  input  logic [MaxAddrWidth-1:0] host_addr_in,
  input  logic [DataWidth-1:0]    host_data_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [CountWidth-1:0]   result_count_out,
  output logic                    addr_err_out
);

  localparam logic [MaxAddrWidth-1:0] DepthW = MaxAddrWidth'(depth_of(DepthLog2));

  logic [1:0]              state;
  logic                    fin_q;
  logic [MaxAddrWidth-1:0] wr_ptr;

  logic                    rd_oor;
  logic                    host_oor;
  logic                    host_ok;
  logic                    res_wr;
  logic                    res_oor;
  logic                    start_ok;
  logic                    fin_edge;
  logic                    err_set;
  logic                    arr_wr_en;
  logic [DepthLog2-1:0]    arr_wr_addr;
  logic [DataWidth-1:0]    arr_wr_data;

  assign rd_oor   = (read_addr_in >= DepthW);
  assign host_oor = (host_addr_in >= DepthW);
  assign res_oor  = (wr_ptr >= DepthW);
  assign start_ok = (state == ST_IDLE) && start_in;
  assign host_ok  = (state == ST_IDLE) && host_wr_en_in && !host_oor;
  assign res_wr   = (state == ST_RUN) && write_en_in;
  assign fin_edge = (state == ST_RUN) && inst_finish_in && !fin_q;

  assign err_set = (read_en_in && rd_oor)
                 || (host_wr_en_in && ((state != ST_IDLE) || host_oor))
                 || (res_wr && res_oor);

  // Host and result writes are mutually exclusive by state, so one port suffices.
  assign arr_wr_en   = !Rst && (host_ok || (res_wr && !res_oor));
  assign arr_wr_addr = host_ok ? host_addr_in[DepthLog2-1:0] : wr_ptr[DepthLog2-1:0];
  assign arr_wr_data = host_ok ? host_data_in : write_data_in;

  conv_mem_array #(
    .DataWidth (DataWidth),
    .DepthLog2 (DepthLog2)
  ) u_array (
    .Clk     (Clk),
    .Rst     (Rst),
    .rd_en   (read_en_in),
    .rd_zero (rd_oor),
    .rd_addr (read_addr_in[DepthLog2-1:0]),
    .rd_data (read_rdata_out),
    .wr_en   (arr_wr_en),
    .wr_addr (arr_wr_addr),
    .wr_data (arr_wr_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= ST_IDLE;
      inst_tag_out     <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      result_count_out <= '0;
      addr_err_out     <= 1'b0;
      wr_ptr           <= '0;
      fin_q            <= 1'b1;
    end else begin
      done_out <= fin_edge;
      // Forcing the history high on launch hides a finish level left over from the last instruction.
      fin_q    <= start_ok ? 1'b1 : inst_finish_in;
      if (err_set) begin
        addr_err_out <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            state            <= ST_RUN;
            inst_tag_out     <= ~inst_tag_out;
            wr_ptr           <= wr_base_in;
            result_count_out <= '0;
            busy_out         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (write_en_in) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (result_count_out != '1) begin
              result_count_out <= result_count_out + 1'b1;
            end
          end
          if (fin_edge) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_conv_mem_responder;

  localparam int DEPTH = 4096;
  localparam int CW    = 4;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          Clk;
  logic          Rst;
  logic [31:0]   read_addr_in;
  logic          read_en_in;
  logic [31:0]   read_rdata_out;
  logic          write_en_in;
  logic [31:0]   write_data_in;
  logic          inst_finish_in;
  logic          inst_tag_out;
  logic          start_in;
  logic [31:0]   wr_base_in;
  logic          host_wr_en_in;
  logic [31:0]   host_addr_in;
  logic [31:0]   host_data_in;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] result_count_out;
  logic          addr_err_out;

  int total = 0;
  int bad   = 0;

  conv_mem_responder #(
    .DataWidth    (32),
    .MaxAddrWidth (32),
    .DepthLog2    (12),
    .CountWidth   (CW)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .read_addr_in     (read_addr_in),
    .read_en_in       (read_en_in),
    .read_rdata_out   (read_rdata_out),
    .write_en_in      (write_en_in),
    .write_data_in    (write_data_in),
    .inst_finish_in   (inst_finish_in),
    .inst_tag_out     (inst_tag_out),
    .start_in         (start_in),
    .wr_base_in       (wr_base_in),
    .host_wr_en_in    (host_wr_en_in),
    .host_addr_in     (host_addr_in),
    .host_data_in     (host_data_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .result_count_out (result_count_out),
    .addr_err_out     (addr_err_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state: what the outputs must be after each clock edge.
  logic [31:0]   m_mem [DEPTH];
  logic [31:0]   m_rdata;
  logic [31:0]   m_ptr;
  logic          m_tag, m_busy, m_done, m_err, m_fin_prev;
  logic [CW-1:0] m_cnt;
  int            m_phase;  // 0 idle, 1 running, 2 completing

  task automatic model_step();
    logic [31:0] nr;
    logic        w_do;
    logic [11:0] w_a;
    logic [31:0] w_d;
    if (Rst) begin
      m_rdata = 0; m_tag = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      m_err = 0; m_ptr = 0; m_fin_prev = 1; m_phase = 0;
      return;
    end
    w_do = 0; w_a = 0; w_d = 0;
    nr = m_rdata;
    if (read_en_in) begin
      if (read_addr_in >= DEPTH) begin
        nr = 0;
        m_err = 1;
      end else begin
        nr = m_mem[read_addr_in[11:0]];
      end
    end
    m_done = 0;
    if (m_phase == 0) begin
      if (host_wr_en_in) begin
        if (host_addr_in < DEPTH) begin
          w_do = 1; w_a = host_addr_in[11:0]; w_d = host_data_in;
        end else begin
          m_err = 1;
        end
      end
      if (start_in) begin
        m_tag = !m_tag; m_ptr = wr_base_in; m_cnt = 0; m_busy = 1;
        m_phase = 1; m_fin_prev = 1;
      end else begin
        m_fin_prev = inst_finish_in;
      end
    end else begin
      if (host_wr_en_in) m_err = 1;
      if (m_phase == 1) begin
        if (write_en_in) begin
          if (m_ptr < DEPTH) begin
            w_do = 1; w_a = m_ptr[11:0]; w_d = write_data_in;
          end else begin
            m_err = 1;
          end
          m_ptr = m_ptr + 1;
          if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        end
        if (inst_finish_in && !m_fin_prev) begin
          m_phase = 2;
          m_done = 1;
        end
      end else begin
        m_phase = 0;
        m_busy = 0;
      end
      m_fin_prev = inst_finish_in;
    end
`ifdef CONV_MEM_RDFWD_EN
    if (w_do && read_en_in && (read_addr_in < DEPTH) && (read_addr_in[11:0] == w_a)) nr = w_d;
`endif
    if (w_do) m_mem[w_a] = w_d;
    m_rdata = nr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rdata", read_rdata_out, m_rdata);
    chk("tag", 32'(inst_tag_out), 32'(m_tag));
    chk("busy", 32'(busy_out), 32'(m_busy));
    chk("done", 32'(done_out), 32'(m_done));
    chk("count", 32'(result_count_out), 32'(m_cnt));
    chk("err", 32'(addr_err_out), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #2;
    compare_all();
  endtask

  task automatic quiet();
    read_en_in = 0; write_en_in = 0; start_in = 0; host_wr_en_in = 0;
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    host_wr_en_in = 1; host_addr_in = 32'(a); host_data_in = d;
    tick();
    host_wr_en_in = 0;
  endtask

  task automatic rd(input int a);
    read_en_in = 1; read_addr_in = 32'(a);
    tick();
    read_en_in = 0;
  endtask

  task automatic launch(input int base);
    start_in = 1; wr_base_in = 32'(base);
    tick();
    start_in = 0;
  endtask

  task automatic finish_pulse();
    inst_finish_in = 0; tick();
    inst_finish_in = 1; tick();
    tick();
  endtask

  initial begin
    Rst = 1; read_addr_in = 0; write_data_in = 0; inst_finish_in = 0;
    wr_base_in = 0; host_addr_in = 0; host_data_in = 0;
    quiet();
    tick(); tick();
    chk("rst_rdata", read_rdata_out, 0);
    chk("rst_tag", 32'(inst_tag_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_cnt", 32'(result_count_out), 0);
    chk("rst_err", 32'(addr_err_out), 0);
    Rst = 0;

    for (int i = 0; i < DEPTH; i++) host_wr(i, $urandom);

    // Preload and consecutive reads.
    for (int i = 0; i < 4; i++) host_wr(i, 32'(10 + i));
    read_en_in = 1;
    for (int i = 0; i < 4; i++) begin
      read_addr_in = 32'(i);
      tick();
      chk("seq_rd", read_rdata_out, 32'(10 + i));
      chk("seq_rd_model", m_rdata, 32'(10 + i));
    end
    read_en_in = 0;
    tick();
    chk("rd_hold", read_rdata_out, 13);

    // Instruction with five results at base 100.
    launch(100);
    chk("tag_toggle", 32'(inst_tag_out), 1);
    chk("busy_run", 32'(busy_out), 1);
    for (int i = 1; i <= 5; i++) begin
      write_en_in = 1; write_data_in = 32'(i);
      tick();
    end
    write_en_in = 0;
    chk("count5", 32'(result_count_out), 5);
    inst_finish_in = 1;
    tick();
    chk("done_pulse", 32'(done_out), 1);
    tick();
    chk("done_clear", 32'(done_out), 0);
    chk("busy_idle", 32'(busy_out), 0);
    for (int i = 0; i < 5; i++) begin
      rd(100 + i);
      chk("result_mem", read_rdata_out, 32'(i + 1));
    end

    // Finish level held over from the previous instruction is not a completion.
    launch(200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale_finish", 32'(done_out), 0);
    end
    inst_finish_in = 0; tick();
    inst_finish_in = 1; tick();
    chk("fresh_finish", 32'(done_out), 1);
    tick();
    chk("busy_after", 32'(busy_out), 0);

    // Host write while running is dropped and flagged.
    host_wr(7, 77);
    chk("err_clean", 32'(addr_err_out), 0);
    launch(300);
    host_wr(7, 999);
    chk("host_run_err", 32'(addr_err_out), 1);
    finish_pulse();
    rd(7);
    chk("host_run_drop", read_rdata_out, 77);

    // Out-of-range read.
    rd(4096);
    chk("oor_rdata", read_rdata_out, 0);
    chk("oor_err", 32'(addr_err_out), 1);

    // Same-cycle write/read collision.
    host_wr(50, 500);
    host_wr_en_in = 1; host_addr_in = 50; host_data_in = 501;
    read_en_in = 1; read_addr_in = 50;
    tick();
    quiet();
`ifdef CONV_MEM_RDFWD_EN
    chk("collide", read_rdata_out, 501);
`else
    chk("collide", read_rdata_out, 500);
`endif
    rd(50);
    chk("collide_after", read_rdata_out, 501);

    // Result counter saturation.
    launch(400);
    write_en_in = 1;
    for (int i = 0; i < 20; i++) begin
      write_data_in = $urandom;
      tick();
    end
    write_en_in = 0;
    chk("count_sat", 32'(result_count_out), 32'(CNT_MAX));
    finish_pulse();

    // Reset in the middle of an instruction.
    launch(300);
    write_en_in = 1;
    tick(); tick();
    write_en_in = 0;
    chk("cnt_before_rst", 32'(result_count_out), 2);
    Rst = 1;
    tick();
    Rst = 0;
    chk("midrst_tag", 32'(inst_tag_out), 0);
    chk("midrst_busy", 32'(busy_out), 0);
    chk("midrst_cnt", 32'(result_count_out), 0);
    chk("midrst_err", 32'(addr_err_out), 0);

    // Randomized traffic over a narrow address window to provoke collisions.
    for (int c = 0; c < 4000; c++) begin
      read_en_in     = 1'($urandom_range(0, 1));
      read_addr_in   = ($urandom_range(0, 29) == 0) ? 32'(4096 + $urandom_range(0, 50))
                                                    : 32'($urandom_range(0, 63));
      write_en_in    = ($urandom_range(0, 2) != 0);
      write_data_in  = $urandom;
      start_in       = ($urandom_range(0, 5) == 0);
      wr_base_in     = ($urandom_range(0, 7) == 0) ? 32'(4093) : 32'($urandom_range(0, 40));
      host_wr_en_in  = ($urandom_range(0, 3) == 0);
      host_addr_in   = ($urandom_range(0, 29) == 0) ? 32'(5000) : 32'($urandom_range(0, 63));
      host_data_in   = $urandom;
      if ($urandom_range(0, 7) == 0) inst_finish_in = ~inst_finish_in;
      Rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    Rst = 0;
    quiet();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Memory-side responder for the convolution controller's streaming interface.
- Services the controller's read-address stream with registered read data, and captures the controller's result write stream into the same memory.
- Drives the instruction-tag handshake: toggles the tag to launch an instruction, then detects completion.
- Host preload port fills weights/feature data while idle. Sits between the conv controller and the host/DMA side.

Parameters:
- DataWidth, 32, width of every data word.
- MaxAddrWidth, 32, width of read/write/base addresses.
- DepthLog2, 12, log2 of internal memory depth in words (4096).
- CountWidth, 18, width of the per-instruction result counter.

Ports:
- Clk  in  1  single clock for all logic
- Rst  in  1  synchronous active-high reset
- read_addr_in  in  MaxAddrWidth  word address requested by controller
- read_en_in  in  1  read request qualifier
- read_rdata_out  out  DataWidth  read data, 1-cycle latency
- write_en_in  in  1  result word valid from controller
- write_data_in  in  DataWidth  result word
- inst_finish_in  in  1  level "instruction complete" from controller
- inst_tag_out  out  1  instruction tag; toggle = new instruction
- start_in  in  1  host pulse: launch next instruction
- wr_base_in  in  MaxAddrWidth  result base address, sampled on accepted start
- host_wr_en_in  in  1  host preload write
- host_addr_in  in  MaxAddrWidth  host preload address
- host_data_in  in  DataWidth  host preload data
- busy_out  out  1  instruction in flight
- done_out  out  1  one-cycle completion pulse
- result_count_out  out  CountWidth  results captured by the current/last instruction
- addr_err_out  out  1  sticky out-of-range or illegal-access flag

Behaviour:
- Reset: read_rdata_out=0, inst_tag_out=0, busy_out=0, done_out=0, result_count_out=0, addr_err_out=0, state=IDLE, write pointer=0, finish-edge register=1 (suppresses a false edge). Memory contents are not cleared.
- Read path, in all states:
  - If read_en_in=1, the next cycle read_rdata_out = mem[read_addr_in].
  - If read_addr_in >= 2^DepthLog2, read_rdata_out=0 and addr_err_out is set.
  - If read_en_in=0, read_rdata_out holds its value.
  - Back-to-back reads every cycle are supported.
- Read/write collision on the same address: read-first (returns old data).
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_in: toggle inst_tag_out, write pointer <= wr_base_in, result_count_out <= 0, busy_out <= 1.
  - RUN: each write_en_in=1 writes mem[write pointer] and increments both the write pointer and result_count_out.
    - Out-of-range pointer: write dropped, count still increments, addr_err_out set.
    - result_count_out saturates at all-ones.
  - RUN -> DONE on a rising edge of inst_finish_in (registered previous value 0, current 1).
    - A level still high from the prior instruction is not an edge; the previous-value register is forced to 1 on start.
  - DONE: done_out=1 for exactly one cycle, busy_out <= 0 -> IDLE.
- start_in is ignored outside IDLE.
- write_en_in is ignored outside RUN.
- Host preload:
  - Accepted only in IDLE.
  - If host_wr_en_in is asserted in RUN/DONE, the write is dropped and addr_err_out is set.
  - Host write out of range: dropped, addr_err_out set.
  - start_in and host_wr_en_in in the same IDLE cycle: the host write completes and the start is accepted.
- addr_err_out clears only on Rst.
- Reset mid-RUN: immediate return to IDLE. The tag returns to 0; the controller must be reset together.

Optional Feature:
- Macro: CONV_MEM_RDFWD_EN.
- Defined: read/write collision on the same address in the same cycle returns the newly written data (write-first forwarding, covering both result and host writes).
- Undefined: read-first, as above.

Decomposition:
- Package conv_mem_pkg holds:
  - the state encoding (IDLE, RUN, DONE)
  - default widths (DataWidth, DepthLog2, CountWidth)
  - the memory depth constant derived from DepthLog2
- One natural sub-module: conv_mem_array, a simple dual-port RAM with:
  - one synchronous read port
  - one write port, muxed between result and host
  - the forwarding option inside it

Test Plan:
- Preload mem[0..3]=10,11,12,13 via host; read_en_in with addresses 0,1,2,3 on consecutive cycles -> read_rdata_out=10,11,12,13 one cycle after each request.
- start_in with wr_base_in=100 -> inst_tag_out toggles 0->1, busy_out=1. Then 5 write_en_in pulses with data 1..5 -> mem[100..104]=1..5, result_count_out=5.
- inst_finish_in held high, then second start -> no done_out until inst_finish_in falls then rises again; then done_out pulses once and busy_out=0.
- read_addr_in=4096 with DepthLog2=12 -> read_rdata_out=0 next cycle, addr_err_out=1 and stays 1 until Rst.
- host_wr_en_in during RUN at address 7 -> mem[7] unchanged, addr_err_out=1. Write and read both to address 50 in the same cycle -> old value returned; new value returned when CONV_MEM_RDFWD_EN is defined.
- Rst asserted mid-RUN after 2 results -> next cycle state IDLE, inst_tag_out=0, busy_out=0, result_count_out=0.
